// File: rtl/airi5c_ahb_pkg.sv
// Shared AHB-Lite encodings and bridge types for the AIRISC memory fabric.
package airi5c_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE     = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;

    localparam logic [2:0] HSIZE_BYTE      = 3'b000;
    localparam logic [2:0] HSIZE_HALF      = 3'b001;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;

    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } bridge_state_t;

    // Result of decoding a Wishbone byte-lane select.
    typedef struct packed {
        logic       legal;
        logic [2:0] hsize;
        logic [1:0] offset;
    } lane_t;

endpackage

// File: rtl/wb_ahb_bridge_if.sv
// Bus bundles for the bridge: Wishbone-classic and AHB-Lite single-transfer.
interface wb_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

interface ahb_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/wb_ahb_bridge_sel_decode.sv
// Maps a Wishbone byte-lane select onto AHB size and low address bits.
module wb_ahb_sel_decode
    import airi5c_ahb_pkg::*;
(
    input  logic [3:0] sel,
    output lane_t      lane
);

    // Only naturally aligned byte/half/word patterns are legal.
    always_comb begin
        lane = '{legal: 1'b0, hsize: HSIZE_WORD, offset: 2'd0};
        case (sel)
            4'b1111: lane = '{legal: 1'b1, hsize: HSIZE_WORD, offset: 2'd0};
            4'b0011: lane = '{legal: 1'b1, hsize: HSIZE_HALF, offset: 2'd0};
            4'b1100: lane = '{legal: 1'b1, hsize: HSIZE_HALF, offset: 2'd2};
            4'b0001: lane = '{legal: 1'b1, hsize: HSIZE_BYTE, offset: 2'd0};
            4'b0010: lane = '{legal: 1'b1, hsize: HSIZE_BYTE, offset: 2'd1};
            4'b0100: lane = '{legal: 1'b1, hsize: HSIZE_BYTE, offset: 2'd2};
            4'b1000: lane = '{legal: 1'b1, hsize: HSIZE_BYTE, offset: 2'd3};
            default: lane = '{legal: 1'b0, hsize: HSIZE_WORD, offset: 2'd0};
        endcase
    end

endmodule

// File: rtl/wb_ahb_bridge.sv
// Wishbone-classic slave to AHB-Lite single-transfer master, one transfer in flight.
module wb_ahb_bridge
    import airi5c_ahb_pkg::*;
#(
    parameter logic [31:0] ADDR_MASK = 32'h00FF_FFFF,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic  clk,
    input  logic  nreset,
    wb_if.slave   wb,
    ahb_if.master ahb,
    output logic  err_o,
    input  logic  err_clr_i
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    bridge_state_t state_q, state_d;
    logic          ack_q, ack_d;
    logic [31:0]   rdat_q, rdat_d;
    logic [31:0]   haddr_q, haddr_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic [1:0]    htrans_q, htrans_d;
    logic [31:0]   hwdata_q, hwdata_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          err_q, err_d;
    logic          abort_q, abort_d;
    logic [CW-1:0] tcnt_q, tcnt_d;

    lane_t lane;
    logic  req;
    logic  aborted;
    logic  expired;
    logic  err_set;

    wb_ahb_sel_decode u_sel_decode (
        .sel  (wb.wbs_sel_i),
        .lane (lane)
    );

    assign req     = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign aborted = abort_q | ~req;
    assign expired = (tcnt_q == CW'(TIMEOUT - 1));

    assign wb.wbs_ack_o  = ack_q;
    assign wb.wbs_dat_o  = rdat_q;
    assign ahb.haddr     = haddr_q;
    assign ahb.hwrite    = hwrite_q;
    assign ahb.hsize     = hsize_q;
    assign ahb.hburst    = HBURST_SINGLE;
    assign ahb.hmastlock = 1'b0;
    assign ahb.hprot     = HPROT_DATA_PRIV;
    assign ahb.htrans    = htrans_q;
    assign ahb.hwdata    = hwdata_q;
    assign err_o         = err_q;

    // State and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_WORD;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= '0;
            wdat_q   <= '0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            htrans_q <= htrans_d;
            hwdata_q <= hwdata_d;
            wdat_q   <= wdat_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        rdat_d   = rdat_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        htrans_d = htrans_q;
        hwdata_d = hwdata_q;
        wdat_d   = wdat_q;
        abort_d  = abort_q;
        tcnt_d   = tcnt_q;
        err_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                tcnt_d  = '0;
                if (req && !ack_q) begin
                    if (lane.legal) begin
                        haddr_d  = (wb.wbs_adr_i & ADDR_MASK & ~32'h3) | {30'd0, lane.offset};
                        hwrite_d = wb.wbs_we_i;
                        hsize_d  = lane.hsize;
                        wdat_d   = wb.wbs_dat_i;
                        htrans_d = HTRANS_NONSEQ;
                        state_d  = ST_ADDR;
                    end else begin
                        ack_d   = 1'b1;
                        rdat_d  = '0;
                        err_set = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end

            // A dropped cyc/stb is remembered; the AHB side still runs to completion
            // and only the Wishbone ack is withheld.
            ST_ADDR, ST_DATA: begin
                if (!req) abort_d = 1'b1;
                if (ahb.hready) begin
                    if (state_q == ST_ADDR) begin
                        htrans_d = HTRANS_IDLE;
                        hwdata_d = wdat_q;
                        state_d  = ST_DATA;
                    end else begin
                        tcnt_d = '0;
                        if (ahb.hresp) err_set = 1'b1;
                        if (aborted) begin
                            state_d = ST_IDLE;
                        end else begin
                            rdat_d  = ahb.hresp ? 32'h0 : ahb.hrdata;
                            ack_d   = 1'b1;
                            state_d = ST_ACK;
                        end
                    end
                end else if (expired) begin
                    htrans_d = HTRANS_IDLE;
                    tcnt_d   = '0;
                    err_set  = 1'b1;
                    if (aborted) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdat_d  = '0;
                        ack_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            ST_ACK: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                ack_d    = 1'b0;
                htrans_d = HTRANS_IDLE;
                state_d  = ST_IDLE;
            end
        endcase

        err_d = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    end

endmodule
